mem_spi_arbiter: RTL and testbench

//  Shares the single mem_spi_controller between two transaction sources: requester 0 (mem_txn_fsm) and requester 1
//  (status/WIP poller or boot loader). Grants one whole flash transaction at a time, from in_start to out_done.

---
 rtl/mem_spi_arbiter_pkg.sv | 31 +++
 rtl/mem_spi_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mem_spi_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_spi_arbiter_pkg.sv
// Shared types and constants for the SPI controller arbiter.
package mem_spi_arbiter_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned GRANT_W = 2;

  // Arbiter FSM encoding
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_START = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_t;

  // One-hot grant constants
  localparam logic [GRANT_W-1:0] GRANT_NONE = 2'b00;
  localparam logic [GRANT_W-1:0] GRANT_REQ0 = 2'b01;
  localparam logic [GRANT_W-1:0] GRANT_REQ1 = 2'b10;

  // Transaction configuration latched from the winning requester
  typedef struct packed {
    logic r_w;
    logic quad_enable;
    logic qed;
  } spi_cfg_t;

  // One-hot grant for a requester index
  function automatic logic [GRANT_W-1:0] grant_of(input logic idx);
    return idx ? GRANT_REQ1 : GRANT_REQ0;
  endfunction

endpackage

// File: rtl/mem_spi_arbiter.sv
// Two-source arbiter for a single SPI flash controller: grants one whole
// transaction (start to done) at a time and muxes the byte streams.
module mem_spi_arbiter
  import mem_spi_arbiter_pkg::*;
#(
  parameter bit          RR_MODE     = 1'b1,
  parameter int unsigned TIMEOUT_W   = 16,
  parameter int unsigned TIMEOUT_MAX = 50000
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_start,
  input  logic              req0_r_w,
  input  logic              req0_quad_enable,
  input  logic              req0_qed,
  output logic              req0_ack,
  output logic              req0_done,
  input  logic              req0_tx_valid,
  input  logic [DATA_W-1:0] req0_tx_data,
  output logic              req0_tx_ready,
  output logic              req0_rx_valid,
  output logic [DATA_W-1:0] req0_rx_data,
  input  logic              req0_rx_ready,

  input  logic              req1_start,
  input  logic              req1_r_w,
  input  logic              req1_quad_enable,
  input  logic              req1_qed,
  output logic              req1_ack,
  output logic              req1_done,
  input  logic              req1_tx_valid,
  input  logic [DATA_W-1:0] req1_tx_data,
  output logic              req1_tx_ready,
  output logic              req1_rx_valid,
  output logic [DATA_W-1:0] req1_rx_data,
  input  logic              req1_rx_ready,

  output logic              spi_start,
  output logic              spi_r_w,
  output logic              spi_quad_enable,
  output logic              spi_qed,
  input  logic              spi_done,
  output logic              spi_tx_valid,
  output logic [DATA_W-1:0] spi_tx_data,
  input  logic              spi_tx_ready,
  input  logic              spi_rx_valid,
  input  logic [DATA_W-1:0] spi_rx_data,
  output logic              spi_rx_ready,

  output logic [GRANT_W-1:0] grant,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [TIMEOUT_W-1:0] WDOG_MAX  = TIMEOUT_W'(TIMEOUT_MAX);
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);

  arb_state_t           state, state_next;
  logic                 rr_last;
  logic                 winner;
  logic                 any_req;
  spi_cfg_t             cfg;
  spi_cfg_t             winner_cfg;
  logic [TIMEOUT_W-1:0] wdog;

  assign any_req = req0_start | req1_start;

  // Winner selection among the current requesters
  always_comb begin
    winner = 1'b0;
    if (RR_MODE) begin
      if (req0_start && req1_start) winner = ~rr_last;
      else                          winner = req1_start;
    end else begin
      winner = ~req0_start;
    end
    winner_cfg = winner ? spi_cfg_t'{req1_r_w, req1_quad_enable, req1_qed}
                        : spi_cfg_t'{req0_r_w, req0_quad_enable, req0_qed};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:  if (any_req) state_next = ARB_START;
      ARB_START: state_next = ARB_BUSY;
      ARB_BUSY:  if (spi_done) state_next = ARB_IDLE;
      default:   state_next = ARB_IDLE;
    endcase
  end

  // FSM outputs decoded from registered state and grant
  always_comb begin
    spi_start = 1'b0;
    req0_ack  = 1'b0;
    req1_ack  = 1'b0;
    busy      = 1'b0;
    req0_done = 1'b0;
    req1_done = 1'b0;
    case (state)
      ARB_START: begin
        spi_start = 1'b1;
        req0_ack  = grant[0];
        req1_ack  = grant[1];
        busy      = 1'b1;
      end
      ARB_BUSY: begin
        busy      = 1'b1;
        req0_done = grant[0] & spi_done;
        req1_done = grant[1] & spi_done;
      end
      default: ;
    endcase
  end

  // Grant, latched config and round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      grant   <= GRANT_NONE;
      cfg     <= '0;
      rr_last <= 1'b1;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            grant <= grant_of(winner);
            cfg   <= winner_cfg;
          end
        end
        ARB_START: rr_last <= grant[1];
        ARB_BUSY:  if (spi_done) grant <= GRANT_NONE;
        default:   grant <= GRANT_NONE;
      endcase
    end
  end

  assign spi_r_w         = cfg.r_w;
  assign spi_quad_enable = cfg.quad_enable;
  assign spi_qed         = cfg.qed;

  // Watchdog: counts stalled BUSY cycles, saturates and flags a sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog        <= '0;
      timeout_err <= 1'b0;
    end else if (state == ARB_IDLE && any_req) begin
      wdog <= '0;
    end else if (state == ARB_BUSY && !spi_done && wdog != WDOG_MAX) begin
      wdog <= wdog + TIMEOUT_W'(1);
      if (wdog == WDOG_LAST) timeout_err <= 1'b1;
    end
  end

  // Byte-stream routing on the registered grant
  always_comb begin
    spi_tx_valid  = 1'b0;
    spi_tx_data   = '0;
    spi_rx_ready  = 1'b0;
    req0_tx_ready = 1'b0;
    req0_rx_valid = 1'b0;
    req0_rx_data  = '0;
    req1_tx_ready = 1'b0;
    req1_rx_valid = 1'b0;
    req1_rx_data  = '0;
    if (grant[0]) begin
      spi_tx_valid  = req0_tx_valid;
      spi_tx_data   = req0_tx_data;
      spi_rx_ready  = req0_rx_ready;
      req0_tx_ready = spi_tx_ready;
      req0_rx_valid = spi_rx_valid;
      req0_rx_data  = spi_rx_data;
    end else if (grant[1]) begin
      spi_tx_valid  = req1_tx_valid;
      spi_tx_data   = req1_tx_data;
      spi_rx_ready  = req1_rx_ready;
      req1_tx_ready = spi_tx_ready;
      req1_rx_valid = spi_rx_valid;
      req1_rx_data  = spi_rx_data;
    end
  end

endmodule

// File: tb/tb_mem_spi_arbiter.sv
// Directed bench for mem_spi_arbiter: a round-robin instance with a short
// watchdog, plus a fixed-priority instance run in lockstep for ordering.
module tb_mem_spi_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic       req0_start, req0_r_w, req0_quad_enable, req0_qed;
  logic       req1_start, req1_r_w, req1_quad_enable, req1_qed;
  logic       req0_tx_valid, req1_tx_valid, req0_rx_ready, req1_rx_ready;
  logic [7:0] req0_tx_data, req1_tx_data;
  logic       spi_done, spi_tx_ready, spi_rx_valid;
  logic [7:0] spi_rx_data;
  logic       fp_req0_start, fp_req1_start;

  logic       req0_ack, req0_done, req0_tx_ready, req0_rx_valid;
  logic       req1_ack, req1_done, req1_tx_ready, req1_rx_valid;
  logic [7:0] req0_rx_data, req1_rx_data, spi_tx_data;
  logic       spi_start, spi_r_w, spi_quad_enable, spi_qed, spi_tx_valid, spi_rx_ready;
  logic [1:0] grant;
  logic       busy, timeout_err;

  logic       fp_req0_ack, fp_req0_done, fp_req0_tx_ready, fp_req0_rx_valid;
  logic       fp_req1_ack, fp_req1_done, fp_req1_tx_ready, fp_req1_rx_valid;
  logic [7:0] fp_req0_rx_data, fp_req1_rx_data, fp_spi_tx_data;
  logic       fp_spi_start, fp_spi_r_w, fp_spi_quad_enable, fp_spi_qed;
  logic       fp_spi_tx_valid, fp_spi_rx_ready;
  logic [1:0] fp_grant;
  logic       fp_busy, fp_timeout_err;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mem_spi_arbiter #(.RR_MODE(1'b1), .TIMEOUT_W(16), .TIMEOUT_MAX(20)) dut (
    .clk(clk), .rst(rst),
    .req0_start(req0_start), .req0_r_w(req0_r_w), .req0_quad_enable(req0_quad_enable),
    .req0_qed(req0_qed), .req0_ack(req0_ack), .req0_done(req0_done),
    .req0_tx_valid(req0_tx_valid), .req0_tx_data(req0_tx_data), .req0_tx_ready(req0_tx_ready),
    .req0_rx_valid(req0_rx_valid), .req0_rx_data(req0_rx_data), .req0_rx_ready(req0_rx_ready),
    .req1_start(req1_start), .req1_r_w(req1_r_w), .req1_quad_enable(req1_quad_enable),
    .req1_qed(req1_qed), .req1_ack(req1_ack), .req1_done(req1_done),
    .req1_tx_valid(req1_tx_valid), .req1_tx_data(req1_tx_data), .req1_tx_ready(req1_tx_ready),
    .req1_rx_valid(req1_rx_valid), .req1_rx_data(req1_rx_data), .req1_rx_ready(req1_rx_ready),
    .spi_start(spi_start), .spi_r_w(spi_r_w), .spi_quad_enable(spi_quad_enable),
    .spi_qed(spi_qed), .spi_done(spi_done),
    .spi_tx_valid(spi_tx_valid), .spi_tx_data(spi_tx_data), .spi_tx_ready(spi_tx_ready),
    .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data), .spi_rx_ready(spi_rx_ready),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  mem_spi_arbiter #(.RR_MODE(1'b0), .TIMEOUT_W(16), .TIMEOUT_MAX(20)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_start(fp_req0_start), .req0_r_w(req0_r_w), .req0_quad_enable(req0_quad_enable),
    .req0_qed(req0_qed), .req0_ack(fp_req0_ack), .req0_done(fp_req0_done),
    .req0_tx_valid(req0_tx_valid), .req0_tx_data(req0_tx_data), .req0_tx_ready(fp_req0_tx_ready),
    .req0_rx_valid(fp_req0_rx_valid), .req0_rx_data(fp_req0_rx_data), .req0_rx_ready(req0_rx_ready),
    .req1_start(fp_req1_start), .req1_r_w(req1_r_w), .req1_quad_enable(req1_quad_enable),
    .req1_qed(req1_qed), .req1_ack(fp_req1_ack), .req1_done(fp_req1_done),
    .req1_tx_valid(req1_tx_valid), .req1_tx_data(req1_tx_data), .req1_tx_ready(fp_req1_tx_ready),
    .req1_rx_valid(fp_req1_rx_valid), .req1_rx_data(fp_req1_rx_data), .req1_rx_ready(req1_rx_ready),
    .spi_start(fp_spi_start), .spi_r_w(fp_spi_r_w), .spi_quad_enable(fp_spi_quad_enable),
    .spi_qed(fp_spi_qed), .spi_done(spi_done),
    .spi_tx_valid(fp_spi_tx_valid), .spi_tx_data(fp_spi_tx_data), .spi_tx_ready(spi_tx_ready),
    .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data), .spi_rx_ready(fp_spi_rx_ready),
    .grant(fp_grant), .busy(fp_busy), .timeout_err(fp_timeout_err)
  );

  // One clock, then settle away from the edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req0_start = 0; req0_r_w = 0; req0_quad_enable = 0; req0_qed = 0;
    req1_start = 0; req1_r_w = 0; req1_quad_enable = 0; req1_qed = 0;
    req0_tx_valid = 0; req1_tx_valid = 0; req0_rx_ready = 0; req1_rx_ready = 0;
    req0_tx_data = 8'h00; req1_tx_data = 8'h00;
    spi_done = 0; spi_tx_ready = 0; spi_rx_valid = 0; spi_rx_data = 8'h00;
    fp_req0_start = 0; fp_req1_start = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset state
    chk("rst_grant", 8'(grant), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_spi_start", 8'(spi_start), 8'h00);
    chk("rst_timeout", 8'(timeout_err), 8'h00);
    chk("rst_cfg", 8'({spi_r_w, spi_quad_enable, spi_qed}), 8'h00);

    // 1: lone req0 read in QSPI mode, rx byte routed back to req0 only
    req0_start = 1; req0_r_w = 1; req0_qed = 1;
    #1;
    chk("t1_idle_start", 8'(spi_start), 8'h00);
    tick();
    chk("t1_ack0", 8'(req0_ack), 8'h01);
    chk("t1_ack1", 8'(req1_ack), 8'h00);
    chk("t1_spi_start", 8'(spi_start), 8'h01);
    chk("t1_grant", 8'(grant), 8'h01);
    chk("t1_cfg", 8'({spi_r_w, spi_quad_enable, spi_qed}), 8'h05);
    req0_start = 0;
    tick();
    chk("t1_ack_pulse", 8'(req0_ack), 8'h00);
    chk("t1_start_pulse", 8'(spi_start), 8'h00);
    chk("t1_busy", 8'(busy), 8'h01);
    spi_rx_valid = 1; spi_rx_data = 8'hA5; req0_rx_ready = 1;
    #1;
    chk("t1_rx0_valid", 8'(req0_rx_valid), 8'h01);
    chk("t1_rx0_data", req0_rx_data, 8'hA5);
    chk("t1_rx1_valid", 8'(req1_rx_valid), 8'h00);
    chk("t1_rx1_data", req1_rx_data, 8'h00);
    chk("t1_rx_ready", 8'(spi_rx_ready), 8'h01);
    spi_rx_valid = 0; spi_done = 1;
    #1;
    chk("t1_done0", 8'(req0_done), 8'h01);
    chk("t1_done1", 8'(req1_done), 8'h00);
    tick();
    spi_done = 0;
    chk("t1_end_grant", 8'(grant), 8'h00);
    chk("t1_end_busy", 8'(busy), 8'h00);

    // 2: contention, round-robin alternates; fixed priority serves req0 first
    do_reset();
    req0_start = 1; req1_start = 1; fp_req1_start = 1;
    for (int i = 0; i < 8; i++) begin
      fp_req0_start = (i < 4);
      tick();
      chk($sformatf("t2_rr_grant%0d", i), 8'(grant), (i % 2 == 0) ? 8'h01 : 8'h02);
      chk($sformatf("t2_fp_grant%0d", i), 8'(fp_grant), (i < 4) ? 8'h01 : 8'h02);
      tick();
      spi_done = 1;
      tick();
      spi_done = 0;
    end
    clear_inputs();

    // 3: req1 write; req0 tx traffic never reaches the controller
    do_reset();
    req1_start = 1; req1_r_w = 0;
    tick();
    chk("t3_grant", 8'(grant), 8'h02);
    chk("t3_ack1", 8'(req1_ack), 8'h01);
    chk("t3_rw", 8'(spi_r_w), 8'h00);
    req1_start = 0;
    tick();
    req1_tx_valid = 1; req1_tx_data = 8'h3C; spi_tx_ready = 1;
    req0_tx_valid = 1; req0_tx_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t3_tx_data%0d", i), spi_tx_data, 8'h3C);
      chk($sformatf("t3_tx_ready0_%0d", i), 8'(req0_tx_ready), 8'h00);
      chk($sformatf("t3_tx_ready1_%0d", i), 8'(req1_tx_ready), 8'h01);
      tick();
    end
    spi_done = 1;
    tick();
    spi_done = 0;
    #1;
    chk("t3_idle_tx_valid", 8'(spi_tx_valid), 8'h00);
    chk("t3_idle_tx_ready1", 8'(req1_tx_ready), 8'h00);
    clear_inputs();

    // 4: config held through BUSY and IDLE, relatched on next START
    do_reset();
    req0_start = 1; req0_r_w = 1; req0_qed = 1;
    tick();
    req0_start = 0;
    tick();
    req0_r_w = 0; req0_qed = 0;
    tick();
    chk("t4_busy_rw", 8'(spi_r_w), 8'h01);
    chk("t4_busy_qed", 8'(spi_qed), 8'h01);
    spi_done = 1;
    tick();
    spi_done = 0;
    chk("t4_idle_cfg", 8'({spi_r_w, spi_qed}), 8'h03);
    req0_start = 1;
    tick();
    chk("t4_restart_cfg", 8'({spi_r_w, spi_qed}), 8'h00);
    req0_start = 0;
    tick();
    spi_done = 1;
    tick();
    spi_done = 0;

    // 5: watchdog trips after 20 stalled BUSY cycles and stays sticky
    do_reset();
    req0_start = 1;
    tick();
    req0_start = 0;
    tick();
    tick(19);
    chk("t5_wdog_19", 8'(timeout_err), 8'h00);
    tick();
    chk("t5_wdog_20", 8'(timeout_err), 8'h01);
    tick(5);
    chk("t5_still_busy", 8'(busy), 8'h01);
    spi_done = 1;
    tick();
    spi_done = 0;
    chk("t5_idle_busy", 8'(busy), 8'h00);
    chk("t5_sticky", 8'(timeout_err), 8'h01);
    req1_start = 1;
    tick();
    req1_start = 0;
    tick();
    spi_done = 1;
    tick();
    spi_done = 0;
    chk("t5_sticky2", 8'(timeout_err), 8'h01);
    do_reset();
    chk("t5_cleared", 8'(timeout_err), 8'h00);

    // 6: reset mid-BUSY, then a stray spi_done is not forwarded
    req0_start = 1; req0_r_w = 1;
    tick();
    req0_start = 0;
    tick();
    chk("t6_busy", 8'(busy), 8'h01);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_grant", 8'(grant), 8'h00);
    chk("t6_busy_rst", 8'(busy), 8'h00);
    chk("t6_outs", 8'({req0_ack, req0_done, req0_tx_ready, req0_rx_valid,
                       req1_ack, req1_done, req1_tx_ready, req1_rx_valid}), 8'h00);
    chk("t6_rw", 8'(spi_r_w), 8'h00);
    spi_done = 1;
    #1;
    chk("t6_stray_done", 8'({req0_done, req1_done}), 8'h00);
    tick();
    spi_done = 0;
    chk("t6_still_idle", 8'(busy), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
